// File: rtl/pipe_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_fetch
//  Description : RV32I instruction-fetch stage and IF/ID pipeline register.
//                Holds the fetch PC, talks to instruction memory through a
//                req/ack handshake, applies EX-stage redirects and the hazard
//                unit's stall/flush controls, and presents the fetched
//                instruction (or a bubble) to decode one cycle after its ack.
//  Ports       : i_clk, i_rst          - clock, synchronous active-high reset
//                o_imem_addr/o_imem_req - fetch address (= PCF) and request
//                i_imem_rdata/i_imem_ack- returned instruction word and strobe
//                i_stall_f/i_stall_d   - hold PCF / hold IF/ID
//                i_flush_d             - load a bubble into IF/ID
//                i_pcsrc_e/i_pctarget_e- redirect request and target from EX
//                o_pcF                 - current fetch PC
//                o_instrD/o_pcD/o_pcplus4D/o_validD - IF/ID register contents
//                o_fetch_cnt           - instructions accepted into D
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [31:0] o_imem_addr,
    output logic        o_imem_req,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_imem_ack,
    input  logic        i_stall_f,
    input  logic        i_stall_d,
    input  logic        i_flush_d,
    input  logic        i_pcsrc_e,
    input  logic [31:0] i_pctarget_e,
    output logic [31:0] o_pcF,
    output logic [31:0] o_instrD,
    output logic [31:0] o_pcD,
    output logic [31:0] o_pcplus4D,
    output logic        o_validD,
    output logic [31:0] o_fetch_cnt
);

    logic [31:0] r_pcf;
    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic [31:0] r_pcplus4_d;
    logic        r_valid_d;
    logic [31:0] r_fetch_cnt;

    logic [31:0] w_pcf_plus4;
    logic        w_kill_d;
    logic        w_capture;

    // Wraps naturally at 2^32.
    assign w_pcf_plus4 = r_pcf + 32'd4;

    // A redirect squashes whatever is in F, so it kills D exactly like a flush.
    assign w_kill_d  = i_flush_d | i_pcsrc_e;

    // Capture only when nothing above it in priority applies. Whenever F is
    // stalled the PC cannot advance on this ack, so capturing would present
    // the same instruction twice; such cycles become bubbles instead.
    assign w_capture = ~w_kill_d & ~i_stall_d & ~i_stall_f & i_imem_ack;

    // ------------------------------------------------------------------
    // Fetch PC
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pcf <= RESET_PC;
        end else if (i_pcsrc_e) begin
            r_pcf <= {i_pctarget_e[31:2], 2'b00};
        end else if (i_stall_f) begin
            r_pcf <= r_pcf;
        end else if (i_imem_ack) begin
            r_pcf <= w_pcf_plus4;
        end
        // No ack: hold so the same address is requested again.
    end

    // ------------------------------------------------------------------
    // IF/ID register and accepted-instruction counter
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_instr_d   <= NOP_INSTR;
            r_pc_d      <= 32'd0;
            r_pcplus4_d <= 32'd0;
            r_valid_d   <= 1'b0;
            r_fetch_cnt <= 32'd0;
        end else if (w_capture) begin
            r_instr_d   <= i_imem_rdata;
            r_pc_d      <= r_pcf;
            r_pcplus4_d <= w_pcf_plus4;
            r_valid_d   <= 1'b1;
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end else if (w_kill_d || !i_stall_d) begin
            // Kill, stall_f-without-advance, or simply no ack: bubble.
            r_instr_d   <= NOP_INSTR;
            r_pc_d      <= 32'd0;
            r_pcplus4_d <= 32'd0;
            r_valid_d   <= 1'b0;
        end
        // Remaining case is a D stall: every field holds.
    end

    assign o_imem_addr = r_pcf;
    assign o_imem_req  = ~i_rst;
    assign o_pcF       = r_pcf;
    assign o_instrD    = r_instr_d;
    assign o_pcD       = r_pc_d;
    assign o_pcplus4D  = r_pcplus4_d;
    assign o_validD    = r_valid_d;
    assign o_fetch_cnt = r_fetch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_fetch
//  Description : Self-checking bench for pipe_fetch. Directed scenarios with
//                literal expectations, followed by randomized traffic checked
//                every cycle against a behavioural model of the fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_fetch;

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic        stall_f;
    logic        stall_d;
    logic        flush_d;
    logic        pcsrc_e;
    logic [31:0] pctarget_e;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pcplus4_d;
    logic        valid_d;
    logic [31:0] fetch_cnt;

    int checks   = 0;
    int failures = 0;

    pipe_fetch dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .o_imem_addr  (imem_addr),
        .o_imem_req   (imem_req),
        .i_imem_rdata (imem_rdata),
        .i_imem_ack   (imem_ack),
        .i_stall_f    (stall_f),
        .i_stall_d    (stall_d),
        .i_flush_d    (flush_d),
        .i_pcsrc_e    (pcsrc_e),
        .i_pctarget_e (pctarget_e),
        .o_pcF        (pc_f),
        .o_instrD     (instr_d),
        .o_pcD        (pc_d),
        .o_pcplus4D   (pcplus4_d),
        .o_validD     (valid_d),
        .o_fetch_cnt  (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: the fetch stage described as "what PC is being
    // fetched" and "which instruction (if any) decode holds".
    // ------------------------------------------------------------------
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcd;
    logic        m_valid;
    logic [31:0] m_cnt;
    bit          m_on = 0;

    always @(posedge clk) begin
        logic        accepted;
        logic        killed;
        logic [31:0] old_pc;
        old_pc = m_pc;
        if (rst) begin
            m_on    = 1;
            m_pc    = 32'h0;
            m_instr = C_NOP;
            m_pcd   = 32'h0;
            m_valid = 0;
            m_cnt   = 0;
        end else begin
            // Fetch PC: redirect wins, a stall freezes it, an ack moves on.
            if (pcsrc_e)       m_pc = pctarget_e & 32'hFFFF_FFFC;
            else if (!stall_f && imem_ack) m_pc = old_pc + 32'd4;

            // Decode: a fresh instruction arrives only if memory answered,
            // neither stage is held and nothing younger is being squashed.
            killed   = flush_d || pcsrc_e;
            accepted = imem_ack && !killed && !stall_d && !stall_f;
            if (accepted) begin
                m_instr = imem_rdata;
                m_pcd   = old_pc;
                m_valid = 1;
                m_cnt   = m_cnt + 32'd1;
            end else if (killed || !stall_d) begin
                m_instr = C_NOP;
                m_pcd   = 32'h0;
                m_valid = 0;
            end
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (m_on) begin
            chk("pcF",       pc_f,      m_pc);
            chk("imem_addr", imem_addr, m_pc);
            chk("imem_req",  {31'd0, imem_req}, {31'd0, ~rst});
            chk("instrD",    instr_d,   m_instr);
            chk("pcD",       pc_d,      m_pcd);
            // A bubble carries pc+4 = 0; a real instruction carries pc+4.
            chk("pcplus4D",  pcplus4_d, m_valid ? m_pcd + 32'd4 : 32'd0);
            chk("validD",    {31'd0, valid_d}, {31'd0, m_valid});
            chk("fetch_cnt", fetch_cnt, m_cnt);
        end
    end

    // One cycle of stimulus: drive, let the edge happen, settle.
    task automatic cyc(input logic ack, input logic [31:0] rd, input logic sf,
                       input logic sd, input logic fl, input logic ps,
                       input logic [31:0] tgt);
        imem_ack   = ack;
        imem_rdata = rd;
        stall_f    = sf;
        stall_d    = sd;
        flush_d    = fl;
        pcsrc_e    = ps;
        pctarget_e = tgt;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] prog [4];

    initial begin
        prog[0] = 32'h0050_0093;
        prog[1] = 32'h00A0_0113;
        prog[2] = 32'h0020_81B3;
        prog[3] = 32'h0000_0013;

        rst = 1;
        imem_ack = 0; imem_rdata = 0; stall_f = 0; stall_d = 0;
        flush_d = 0; pcsrc_e = 0; pctarget_e = 0;

        // Reset with junk on the inputs.
        cyc(1, 32'hDEAD_BEEF, 0, 0, 0, 1, 32'h40);
        cyc(1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
        chk("rst_pcF",   pc_f, 32'h0);
        chk("rst_instr", instr_d, 32'h13);
        chk("rst_valid", {31'd0, valid_d}, 32'd0);
        chk("rst_cnt",   fetch_cnt, 32'd0);
        rst = 0;
        #1;
        chk("req_after_rst", {31'd0, imem_req}, 32'd1);

        // Straight-line fetch of four words.
        for (int i = 0; i < 4; i++) begin
            chk("seq_pcF_pre", pc_f, 32'(i * 4));
            cyc(1, prog[i], 0, 0, 0, 0, 0);
            chk("seq_instrD",  instr_d, prog[i]);
            chk("seq_pcD",     pc_d, 32'(i * 4));
            chk("seq_pcp4D",   pcplus4_d, 32'(i * 4 + 4));
        end
        chk("seq_pcF_end", pc_f, 32'd16);
        chk("seq_cnt",     fetch_cnt, 32'd4);

        // Memory wait states at PCF = 0x10.
        for (int i = 0; i < 3; i++) begin
            cyc(0, 32'hBAD0_0000, 0, 0, 0, 0, 0);
            chk("wait_pcF",   pc_f, 32'h10);
            chk("wait_valid", {31'd0, valid_d}, 32'd0);
        end
        cyc(1, 32'h1111_1111, 0, 0, 0, 0, 0);
        chk("wait_pcD",   pc_d, 32'h10);
        chk("wait_valid1",{31'd0, valid_d}, 32'd1);
        chk("wait_cnt",   fetch_cnt, 32'd5);

        // Load-use stall: D holds 0x10, F holds 0x14.
        cyc(1, 32'h2222_2222, 1, 1, 0, 0, 0);
        chk("lu_pcD",  pc_d, 32'h10);
        chk("lu_pcF",  pc_f, 32'h14);
        chk("lu_cnt",  fetch_cnt, 32'd5);
        cyc(1, 32'h3333_3333, 0, 0, 0, 0, 0);
        chk("lu_pcD2", pc_d, 32'h14);
        chk("lu_cnt2", fetch_cnt, 32'd6);

        // Redirect beats stall; target low bits dropped.
        cyc(1, 32'h4444_4444, 1, 1, 0, 1, 32'h0000_0103);
        chk("br_pcF",   pc_f, 32'h100);
        chk("br_valid", {31'd0, valid_d}, 32'd0);
        chk("br_instr", instr_d, 32'h13);
        cyc(1, 32'h5555_5555, 0, 0, 0, 0, 0);
        chk("br_pcD",   pc_d, 32'h100);

        // PC wrap at the top of the address space.
        cyc(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
        chk("wrap_pcF_pre", pc_f, 32'hFFFF_FFFC);
        cyc(1, 32'h6666_6666, 0, 0, 0, 0, 0);
        chk("wrap_pcF",   pc_f, 32'h0);
        chk("wrap_pcD",   pc_d, 32'hFFFF_FFFC);
        chk("wrap_pcp4D", pcplus4_d, 32'h0);

        // Reset during a redirect.
        rst = 1;
        cyc(1, 32'h7777_7777, 1, 0, 0, 1, 32'h200);
        chk("rr_pcF",   pc_f, 32'h0);
        chk("rr_instr", instr_d, 32'h13);
        chk("rr_pcD",   pc_d, 32'h0);
        chk("rr_pcp4",  pcplus4_d, 32'h0);
        chk("rr_valid", {31'd0, valid_d}, 32'd0);
        chk("rr_cnt",   fetch_cnt, 32'd0);
        rst = 0;

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            cyc($urandom_range(0, 3) != 0, $urandom,
                $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 | 32'($urandom_range(0, 7))
                                            : $urandom);
        end
        rst = 0;
        cyc(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
